// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared mode encodings, lock-FSM states and counter widths
//               for the video lock controller.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam logic [1:0] MODE_NTSC    = 2'd0;
    localparam logic [1:0] MODE_PAL     = 2'd1;
    localparam logic [1:0] MODE_UNKNOWN = 2'd3;

    localparam int HCNT_W = 13;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        ARM     = 2'd2,
        LOCKED  = 2'd3
    } lock_state_t;

endpackage
`default_nettype wire

// File: rtl/video_timing_meter.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_meter
// Description : Registers core sync/de, detects line and frame starts and
//               measures clocks per line and lines per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_meter
    import video_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hs,
    input  logic              vs,
    input  logic              de,
    output logic              ls,
    output logic              fs,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic [HCNT_W-1:0] htotal,
    output logic [VCNT_W-1:0] vtotal,
    output logic              de_d
);

    logic              r_hs_d;
    logic              r_vs_s;
    logic              r_de_d;
    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic [HCNT_W-1:0] r_htotal;
    logic [VCNT_W-1:0] r_vtotal;
    logic              w_ls;
    logic              w_fs;
    logic [HCNT_W-1:0] w_hcnt_inc;
    logic [VCNT_W-1:0] w_vcnt_inc;

    // Syncs idle high, so the history registers reset inactive.
    assign w_ls       = r_hs_d & ~hs;
    assign w_fs       = w_ls & r_vs_s & ~vs;
    assign w_hcnt_inc = (r_hcnt == '1) ? r_hcnt : r_hcnt + HCNT_W'(1);
    assign w_vcnt_inc = (r_vcnt == '1) ? r_vcnt : r_vcnt + VCNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_d   <= 1'b1;
            r_vs_s   <= 1'b1;
            r_de_d   <= 1'b0;
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_htotal <= '0;
            r_vtotal <= '0;
        end else begin
            r_hs_d <= hs;
            r_de_d <= de;
            if (w_ls) begin
                r_vs_s   <= vs;
                r_hcnt   <= '0;
                r_htotal <= w_hcnt_inc;
            end else begin
                r_hcnt <= w_hcnt_inc;
            end
            if (w_fs) begin
                r_vcnt   <= '0;
                r_vtotal <= w_vcnt_inc;
            end else if (w_ls) begin
                r_vcnt <= w_vcnt_inc;
            end
        end
    end

    assign ls     = w_ls;
    assign fs     = w_fs;
    assign hcnt   = r_hcnt;
    assign vcnt   = r_vcnt;
    assign htotal = r_htotal;
    assign vtotal = r_vtotal;
    assign de_d   = r_de_d;

endmodule
`default_nettype wire

// File: rtl/video_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : video_lock_ctrl
// Description : Qualifies core video timing as PAL/NTSC and issues a single
//               counter reset to the HDMI generator, then supervises lock.
// Revision    : 1.0 - initial release
// ============================================================================
module video_lock_ctrl
    import video_pkg::*;
#(
    parameter int PAL_HTOTAL  = 864,
    parameter int PAL_VTOTAL  = 625,
    parameter int NTSC_HTOTAL = 858,
    parameter int NTSC_VTOTAL = 525,
    parameter int H_OFFSET    = 68,
    parameter int V_OFFSET    = 39,
    parameter int LOCK_FRAMES = 3,
    parameter int LOSS_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hs,
    input  logic              vs,
    input  logic              de,
    output logic              vreset,
    output logic              locked,
    output logic [1:0]        mode,
    output logic [HCNT_W-1:0] htotal,
    output logic [VCNT_W-1:0] vtotal
);

    // Totals loaded at a frame start equal the count plus one.
    localparam logic [HCNT_W-1:0] c_pal_h  = HCNT_W'(PAL_HTOTAL - 1);
    localparam logic [VCNT_W-1:0] c_pal_v  = VCNT_W'(PAL_VTOTAL - 1);
    localparam logic [HCNT_W-1:0] c_ntsc_h = HCNT_W'(NTSC_HTOTAL - 1);
    localparam logic [VCNT_W-1:0] c_ntsc_v = VCNT_W'(NTSC_VTOTAL - 1);
    localparam logic [HCNT_W-1:0] c_h_off  = HCNT_W'(H_OFFSET);
    localparam logic [VCNT_W-1:0] c_v_off  = VCNT_W'(V_OFFSET);
    localparam logic [2:0]        c_lock_n = 3'(LOCK_FRAMES);
    localparam logic [2:0]        c_loss_n = 3'(LOSS_FRAMES);

    logic              w_ls;
    logic              w_fs;
    logic              w_frame;
    logic [HCNT_W-1:0] w_hcnt;
    logic [VCNT_W-1:0] w_vcnt;
    logic              w_de_d;
    logic [1:0]        w_class;
    logic              w_match;
    logic [2:0]        w_stable_inc;
    logic [2:0]        w_bad_inc;

    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic [1:0]  r_cand,   w_cand_nxt;
    logic [2:0]  r_stable, w_stable_nxt;
    logic [2:0]  r_bad,    w_bad_nxt;
    logic [1:0]  r_mode,   w_mode_nxt;
    logic        r_vreset, w_vreset_nxt;
    logic        r_vt_valid;

    video_timing_meter u_meter (
        .clk    (clk),
        .reset  (reset),
        .hs     (hs),
        .vs     (vs),
        .de     (de),
        .ls     (w_ls),
        .fs     (w_fs),
        .hcnt   (w_hcnt),
        .vcnt   (w_vcnt),
        .htotal (htotal),
        .vtotal (vtotal),
        .de_d   (w_de_d)
    );

    assign w_frame      = w_ls & w_fs;
    assign w_match      = (w_hcnt == c_h_off) && (w_vcnt == c_v_off);
    assign w_stable_inc = (r_stable == 3'd7) ? r_stable : r_stable + 3'd1;
    assign w_bad_inc    = (r_bad == 3'd7) ? r_bad : r_bad + 3'd1;

    // The first frame start after reset closes a frame of unknown length.
    always_comb begin
        w_class = MODE_UNKNOWN;
        if (r_vt_valid) begin
            if (w_hcnt == c_pal_h && w_vcnt == c_pal_v) begin
                w_class = MODE_PAL;
            end else if (w_hcnt == c_ntsc_h && w_vcnt == c_ntsc_v) begin
                w_class = MODE_NTSC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SEARCH;
            r_cand     <= MODE_UNKNOWN;
            r_stable   <= 3'd0;
            r_bad      <= 3'd0;
            r_mode     <= MODE_UNKNOWN;
            r_vreset   <= 1'b0;
            r_vt_valid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cand   <= w_cand_nxt;
            r_stable <= w_stable_nxt;
            r_bad    <= w_bad_nxt;
            r_mode   <= w_mode_nxt;
            r_vreset <= w_vreset_nxt;
            if (w_frame) begin
                r_vt_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_stable_nxt = r_stable;
        w_bad_nxt    = r_bad;
        w_mode_nxt   = r_mode;
        w_vreset_nxt = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_frame) begin
                    if (w_class != MODE_UNKNOWN) begin
                        w_cand_nxt   = w_class;
                        w_stable_nxt = 3'd1;
                        if (c_lock_n == 3'd1) begin
                            w_state_nxt = ARM;
                            w_mode_nxt  = w_class;
                        end else begin
                            w_state_nxt = MEASURE;
                        end
                    end else begin
                        w_stable_nxt = 3'd0;
                    end
                end
            end
            MEASURE: begin
                if (w_frame) begin
                    if (w_class == r_cand) begin
                        w_stable_nxt = w_stable_inc;
                        if (w_stable_inc == c_lock_n) begin
                            w_state_nxt = ARM;
                            w_mode_nxt  = r_cand;
                        end
                    end else begin
                        w_state_nxt  = SEARCH;
                        w_stable_nxt = 3'd0;
                    end
                end
            end
            ARM: begin
                if (w_frame && w_class != r_mode) begin
                    w_state_nxt  = SEARCH;
                    w_stable_nxt = 3'd0;
                    w_mode_nxt   = MODE_UNKNOWN;
                end else if (w_match && w_de_d) begin
                    w_state_nxt  = LOCKED;
                    w_vreset_nxt = 1'b1;
                    w_bad_nxt    = 3'd0;
                end
            end
            LOCKED: begin
                if (w_frame) begin
                    if (w_class == r_mode) begin
                        w_bad_nxt = 3'd0;
                    end else if (w_bad_inc == c_loss_n) begin
                        w_state_nxt  = SEARCH;
                        w_bad_nxt    = 3'd0;
                        w_stable_nxt = 3'd0;
                        w_mode_nxt   = MODE_UNKNOWN;
                    end else begin
                        w_bad_nxt = w_bad_inc;
                    end
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        vreset = r_vreset;
        locked = (r_state == LOCKED);
        mode   = r_mode;
    end

endmodule
`default_nettype wire

// File: tb/tb_video_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_lock_ctrl
// Description : Directed self-checking bench for video_lock_ctrl using a
//               scaled-down raster so whole lock sequences stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_lock_ctrl;

    localparam int PH = 40;
    localparam int PV = 20;
    localparam int NH = 36;
    localparam int NV = 16;
    localparam int HO = 10;
    localparam int VO = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        de = 1'b0;
    logic        vreset;
    logic        locked;
    logic [1:0]  mode;
    logic [12:0] htotal;
    logic [9:0]  vtotal;

    int n_total = 0;
    int n_bad   = 0;
    int frame_idx, pulses, pulse_frame, pulse_x, pulse_y, wide, falls, fall_frame, rise_err;
    logic prev_vreset, prev_locked;

    video_lock_ctrl #(
        .PAL_HTOTAL  (PH),
        .PAL_VTOTAL  (PV),
        .NTSC_HTOTAL (NH),
        .NTSC_VTOTAL (NV),
        .H_OFFSET    (HO),
        .V_OFFSET    (VO),
        .LOCK_FRAMES (3),
        .LOSS_FRAMES (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .hs     (hs),
        .vs     (vs),
        .de     (de),
        .vreset (vreset),
        .locked (locked),
        .mode   (mode),
        .htotal (htotal),
        .vtotal (vtotal)
    );

    always #5 clk = ~clk;

    // After the edge that consumes pixel x the DUT's hcnt equals x, so the
    // registered vreset shows up on the pixel after (HO, VO).
    task automatic pix(input int x, input int y, input bit kill);
        hs = (x >= 4);
        vs = (y >= 2);
        de = (x >= HO) && (y >= VO) && !kill;
        @(posedge clk);
        #1;
        if (vreset) begin
            pulses++;
            pulse_frame = frame_idx;
            pulse_x = x;
            pulse_y = y;
            if (prev_vreset) wide++;
        end
        if (locked && !prev_locked && !vreset) rise_err++;
        if (prev_locked && !locked) begin
            falls++;
            fall_frame = frame_idx;
        end
        prev_vreset = vreset;
        prev_locked = locked;
    endtask

    task automatic run_frame(input int ht, input int vt, input int y0, input int kill_line);
        if (y0 == 0) frame_idx++;
        for (int y = y0; y < vt; y++) begin
            for (int x = 0; x < ht; x++) begin
                pix(x, y, y == kill_line);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hs = 1'b1;
        vs = 1'b1;
        de = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        frame_idx = 0; pulses = 0; pulse_frame = -1; pulse_x = -1; pulse_y = -1;
        wide = 0; falls = 0; fall_frame = -1; rise_err = 0;
        prev_vreset = vreset;
        prev_locked = locked;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (vreset !== 1'b0) begin n_bad++; $display("FAIL rst_vreset: got %0b want 0", vreset); end
        n_total++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %0b want 0", locked); end
        n_total++; if (mode !== 2'd3) begin n_bad++; $display("FAIL rst_mode: got %0d want 3", mode); end
        n_total++; if (htotal !== 13'd0) begin n_bad++; $display("FAIL rst_htotal: got %0d want 0", htotal); end
        n_total++; if (vtotal !== 10'd0) begin n_bad++; $display("FAIL rst_vtotal: got %0d want 0", vtotal); end
    endtask

    task automatic test_pal_lock();
        do_reset();
        run_frame(PH, PV, 10, -1);
        repeat (3) run_frame(PH, PV, 0, -1);
        n_total++; if (mode !== 2'd3) begin n_bad++; $display("FAIL pal_mode_early: got %0d want 3", mode); end
        n_total++; if (locked !== 1'b0) begin n_bad++; $display("FAIL pal_locked_early: got %0b want 0", locked); end
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL pal_pulse_early: got %0d want 0", pulses); end
        run_frame(PH, PV, 0, -1);
        n_total++; if (pulses !== 1) begin n_bad++; $display("FAIL pal_pulses: got %0d want 1", pulses); end
        n_total++; if (pulse_frame !== 4) begin n_bad++; $display("FAIL pal_pulse_frame: got %0d want 4", pulse_frame); end
        n_total++; if (pulse_x !== HO + 1) begin n_bad++; $display("FAIL pal_pulse_x: got %0d want %0d", pulse_x, HO + 1); end
        n_total++; if (pulse_y !== VO) begin n_bad++; $display("FAIL pal_pulse_y: got %0d want %0d", pulse_y, VO); end
        n_total++; if (locked !== 1'b1) begin n_bad++; $display("FAIL pal_locked: got %0b want 1", locked); end
        n_total++; if (mode !== 2'd1) begin n_bad++; $display("FAIL pal_mode: got %0d want 1", mode); end
        n_total++; if (htotal !== 13'd40) begin n_bad++; $display("FAIL pal_htotal: got %0d want 40", htotal); end
        n_total++; if (vtotal !== 10'd20) begin n_bad++; $display("FAIL pal_vtotal: got %0d want 20", vtotal); end
        repeat (2) run_frame(PH, PV, 0, -1);
        n_total++; if (pulses !== 1) begin n_bad++; $display("FAIL pal_second_pulse: got %0d want 1", pulses); end
        n_total++; if (wide !== 0) begin n_bad++; $display("FAIL pal_pulse_width: got %0d want 0", wide); end
        n_total++; if (rise_err !== 0) begin n_bad++; $display("FAIL pal_lock_align: got %0d want 0", rise_err); end
    endtask

    task automatic test_ntsc_lock();
        do_reset();
        run_frame(NH, NV, 10, -1);
        repeat (5) run_frame(NH, NV, 0, -1);
        n_total++; if (mode !== 2'd0) begin n_bad++; $display("FAIL ntsc_mode: got %0d want 0", mode); end
        n_total++; if (htotal !== 13'd36) begin n_bad++; $display("FAIL ntsc_htotal: got %0d want 36", htotal); end
        n_total++; if (vtotal !== 10'd16) begin n_bad++; $display("FAIL ntsc_vtotal: got %0d want 16", vtotal); end
        n_total++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ntsc_locked: got %0b want 1", locked); end
        n_total++; if (pulse_frame !== 4) begin n_bad++; $display("FAIL ntsc_pulse_frame: got %0d want 4", pulse_frame); end
    endtask

    task automatic test_loss();
        do_reset();
        run_frame(PH, PV, 10, -1);
        repeat (5) run_frame(PH, PV, 0, -1);
        run_frame(PH, PV + 1, 0, -1);
        repeat (2) run_frame(PH, PV, 0, -1);
        n_total++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_single_locked: got %0b want 1", locked); end
        n_total++; if (falls !== 0) begin n_bad++; $display("FAIL loss_single_falls: got %0d want 0", falls); end
        repeat (2) run_frame(PH, PV + 1, 0, -1);
        run_frame(PH, PV, 0, -1);
        n_total++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_locked: got %0b want 0", locked); end
        n_total++; if (mode !== 2'd3) begin n_bad++; $display("FAIL loss_mode: got %0d want 3", mode); end
        n_total++; if (fall_frame !== 11) begin n_bad++; $display("FAIL loss_fall_frame: got %0d want 11", fall_frame); end
        repeat (3) run_frame(PH, PV, 0, -1);
        n_total++; if (pulses !== 2) begin n_bad++; $display("FAIL relock_pulses: got %0d want 2", pulses); end
        n_total++; if (pulse_frame !== 14) begin n_bad++; $display("FAIL relock_frame: got %0d want 14", pulse_frame); end
        n_total++; if (mode !== 2'd1) begin n_bad++; $display("FAIL relock_mode: got %0d want 1", mode); end
    endtask

    task automatic test_de_gap();
        do_reset();
        run_frame(PH, PV, 10, -1);
        repeat (3) run_frame(PH, PV, 0, -1);
        run_frame(PH, PV, 0, VO);
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL degap_no_pulse: got %0d want 0", pulses); end
        n_total++; if (locked !== 1'b0) begin n_bad++; $display("FAIL degap_locked: got %0b want 0", locked); end
        run_frame(PH, PV, 0, -1);
        n_total++; if (pulses !== 1) begin n_bad++; $display("FAIL degap_pulses: got %0d want 1", pulses); end
        n_total++; if (pulse_frame !== 5) begin n_bad++; $display("FAIL degap_frame: got %0d want 5", pulse_frame); end
        n_total++; if (pulse_x !== HO + 1) begin n_bad++; $display("FAIL degap_x: got %0d want %0d", pulse_x, HO + 1); end
    endtask

    task automatic test_alternating();
        do_reset();
        run_frame(PH, PV, 10, -1);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) run_frame(PH, PV, 0, -1);
            else            run_frame(NH, NV, 0, -1);
        end
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL alt_pulses: got %0d want 0", pulses); end
        n_total++; if (mode !== 2'd3) begin n_bad++; $display("FAIL alt_mode: got %0d want 3", mode); end
        n_total++; if (locked !== 1'b0) begin n_bad++; $display("FAIL alt_locked: got %0b want 0", locked); end
    endtask

    task automatic test_reset_before_pulse();
        do_reset();
        run_frame(PH, PV, 10, -1);
        repeat (3) run_frame(PH, PV, 0, -1);
        frame_idx++;
        for (int y = 0; y <= VO; y++) begin
            for (int x = 0; x < PH; x++) begin
                if (y == VO && x == HO + 1) break;
                pix(x, y, 1'b0);
            end
        end
        reset = 1'b1;
        pix(HO + 1, VO, 1'b0);
        reset = 1'b0;
        n_total++; if (vreset !== 1'b0) begin n_bad++; $display("FAIL rstmid_vreset: got %0b want 0", vreset); end
        n_total++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rstmid_locked: got %0b want 0", locked); end
        n_total++; if (mode !== 2'd3) begin n_bad++; $display("FAIL rstmid_mode: got %0d want 3", mode); end
        n_total++; if (htotal !== 13'd0) begin n_bad++; $display("FAIL rstmid_htotal: got %0d want 0", htotal); end
        n_total++; if (vtotal !== 10'd0) begin n_bad++; $display("FAIL rstmid_vtotal: got %0d want 0", vtotal); end
        for (int x = HO + 2; x < PH; x++) pix(x, VO, 1'b0);
        for (int y = VO + 1; y < PV; y++) begin
            for (int x = 0; x < PH; x++) pix(x, y, 1'b0);
        end
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse: got %0d want 0", pulses); end
        repeat (4) run_frame(PH, PV, 0, -1);
        n_total++; if (pulses !== 1) begin n_bad++; $display("FAIL rstmid_relock: got %0d want 1", pulses); end
        n_total++; if (pulse_frame !== 8) begin n_bad++; $display("FAIL rstmid_frame: got %0d want 8", pulse_frame); end
        n_total++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rstmid_locked_end: got %0b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_pal_lock();
        test_ntsc_lock();
        test_loss();
        test_de_gap();
        test_alternating();
        test_reset_before_pulse();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
